regbank_dump_controller: RTL and testbench
==========================================

Name: regbank_dump_controller

Overview:
- Debug-side sequencer for the MIPS register bank.
- On a dump request it halts the pipeline and takes over the bank read-A address through a select line.
- It then walks registers 0..N_REGISTER-1 and streams each word as NB_DATA/8 bytes, LSB first, over a valid/ready byte interface to the UART transmitter.
- When the walk ends it releases the pipeline; it sits between the debug unit and the decode-stage register bank.

Parameters:
- NB_REG, 5, register address width.
- NB_DATA, 32, register data width; must be a multiple of 8.
- N_REGISTER, 32, number of registers dumped.
- RD_LATENCY, 1, cycles from dbg_addr_o change to valid rd_data_i; the bank reads synchronously, so 1.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- dump_start_i  in  1  single-cycle request to start a dump.
- abort_i  in  1  abandon the dump in progress.
- halt_o  out  1  pipeline freeze request.
- halt_ack_i  in  1  pipeline frozen and write-back drained.
- dbg_sel_o  out  1  1 = bank read-A address comes from dbg_addr_o.
- dbg_addr_o  out  NB_REG  register index being read.
- rd_data_i  in  NB_DATA  bank read-A data.
- tx_data_o  out  8  byte to transmitter.
- tx_valid_o  out  1  tx_data_o valid.
- tx_ready_i  in  1  transmitter accepts the byte.
- busy_o  out  1  not IDLE.
- done_o  out  1  one-cycle pulse when a dump completes.

Behaviour:
- Reset (reset_i=0, asynchronous): state IDLE; all outputs 0; reg index, byte counter and shift register cleared.
- Outputs are registered.
- States and transitions:
  - IDLE: dump_start_i=1 -> HALT_REQ; set halt_o=1, busy_o=1, index=0.
  - HALT_REQ: halt_o=1; wait for halt_ack_i=1 -> ADDR.
  - ADDR: dbg_sel_o=1, dbg_addr_o=index; wait RD_LATENCY cycles -> CAPTURE.
  - CAPTURE: latch rd_data_i into the shift register; byte=0 -> SEND.
  - SEND: tx_valid_o=1, tx_data_o=shift[7:0].
    - A transfer happens on a cycle with tx_valid_o and tx_ready_i both 1.
    - On each transfer: shift right 8, byte++.
    - After the last byte (NB_DATA/8-1): if index==N_REGISTER-1 -> DONE, else index++ -> ADDR.
  - DONE: one cycle; done_o=1; halt_o, dbg_sel_o, busy_o drop to 0 on exit -> IDLE.
- Handshake rules:
  - tx_valid_o, once raised, stays high with tx_data_o stable until transferred.
  - tx_ready_i low stalls SEND indefinitely.
  - No bubble between bytes of one word.
- dbg_sel_o is 1 from ADDR through the end of SEND of the last register. halt_o stays 1 across that whole span.
- Timing:
  - First byte is valid RD_LATENCY+2 cycles after entering ADDR.
  - Minimum total dump time with tx_ready_i held high is N_REGISTER*(RD_LATENCY+1+NB_DATA/8)+halt handshake+1 cycles.
- Boundary conditions:
  - dump_start_i while busy_o=1: ignored, no restart.
  - abort_i in any non-IDLE state: next cycle IDLE, halt_o=0, dbg_sel_o=0, tx_valid_o=0, no done_o. Abort takes priority over a transfer completing in the same cycle.
  - dump_start_i and abort_i together in IDLE: start ignored.
  - halt_ack_i dropping after HALT_REQ: ignored; the pipeline is trusted to stay frozen while halt_o=1.
  - Index wrap: never wraps. The index saturates at N_REGISTER-1 and DONE follows.
  - N_REGISTER < 2^NB_REG: only indices 0..N_REGISTER-1 are driven.
  - Reset mid-operation: immediate IDLE with all outputs 0. A partially sent word is not resumed.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_HALT_REQ, ST_ADDR, ST_CAPTURE, ST_SEND, ST_DONE (3 bits);
  - BYTES_PER_WORD = NB_DATA/8;
  - debug byte width 8.
- One sub-module: word_byte_serializer, holding the shift register, byte counter and valid/ready output stage.
  - Inputs: load, word.
  - Outputs: last_byte_sent, tx_*.
- FSM and index counter stay in the top.

Test Plan:
- Preload registers r[i]=0x1000_0000+i; pulse dump_start_i; halt_ack_i 3 cycles later; tx_ready_i=1.
  - Expect 128 bytes: 00,00,00,10, 01,00,00,10 … 1F,00,00,10.
  - done_o pulses once; halt_o=0 the cycle after.
- Same dump with tx_ready_i toggling 1/0 every cycle -> identical byte sequence, tx_data_o stable while tx_valid_o=1 and tx_ready_i=0, no lost or duplicated bytes.
- halt_ack_i held 0 for 50 cycles -> halt_o=1, dbg_sel_o=0, tx_valid_o=0 throughout; first byte appears RD_LATENCY+2 cycles after ADDR is entered.
- abort_i during byte 2 of r5 -> next cycle all outputs 0, no done_o; a new dump_start_i then restarts from r0 byte 0.
- dump_start_i re-pulsed during SEND of r10 -> no effect, sequence continues with r10 byte 1.
- reset_i driven low asynchronously mid-SEND (not clock-aligned) -> outputs 0 immediately; after release, IDLE with busy_o=0.

Source files
------------

// File: rtl/regbank_dump_controller_pkg.sv
// Shared definitions for the register-bank dump controller.
// Holds the FSM state encoding, the debug byte width and word/byte sizing helpers.
package regbank_dump_controller_pkg;

    localparam int unsigned NB_DBG_BYTE     = 8;
    localparam int unsigned NB_STATE        = 3;
    localparam int unsigned NB_DATA_DEFAULT = 32;
    localparam int unsigned BYTES_PER_WORD  = NB_DATA_DEFAULT / NB_DBG_BYTE;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE     = 3'd0,
        ST_HALT_REQ = 3'd1,
        ST_ADDR     = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_SEND     = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Number of debug bytes in a data word of the given width.
    function automatic int unsigned bytes_per_word(input int unsigned nb_data);
        return nb_data / NB_DBG_BYTE;
    endfunction

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regbank_dump_controller_word_byte_serializer.sv
// Word-to-byte serializer with a valid/ready byte output, LSB byte first.
// Ports:
//   clock_i, reset_i   clock and asynchronous active-low reset
//   clear              drop the word in flight and lower tx_valid_o
//   load               capture word and start presenting byte 0
//   word               data word to serialize
//   tx_ready_i         downstream accepts the presented byte
//   tx_data_o          presented byte (low byte of the shift register)
//   tx_valid_o         tx_data_o is valid
//   last_byte_sent_c   the final byte of the word transfers this cycle
module word_byte_serializer
    import regbank_dump_controller_pkg::*;
#(
    parameter int unsigned N_BYTES = BYTES_PER_WORD
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic                              clear,
    input  logic                              load,
    input  logic [N_BYTES*NB_DBG_BYTE-1:0]    word,
    input  logic                              tx_ready_i,
    output logic [NB_DBG_BYTE-1:0]            tx_data_o,
    output logic                              tx_valid_o,
    output logic                              last_byte_sent_c
);

    localparam int unsigned NB_WORD = N_BYTES * NB_DBG_BYTE;
    localparam int unsigned NB_CNT  = cnt_width(N_BYTES);
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(N_BYTES - 1);

    logic [NB_WORD-1:0] shift_q;
    logic [NB_CNT-1:0]  byte_cnt_q;
    logic               transfer_c;

    assign transfer_c       = tx_valid_o & tx_ready_i;
    assign last_byte_sent_c = transfer_c & (byte_cnt_q == LAST_BYTE);
    assign tx_data_o        = shift_q[NB_DBG_BYTE-1:0];

    // Shift register, byte counter and valid flag; clear wins over load and transfer.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
            tx_valid_o <= 1'b0;
        end else if (clear) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
            tx_valid_o <= 1'b0;
        end else if (load) begin
            shift_q    <= word;
            byte_cnt_q <= '0;
            tx_valid_o <= 1'b1;
        end else if (transfer_c) begin
            shift_q    <= shift_q >> NB_DBG_BYTE;
            byte_cnt_q <= byte_cnt_q + NB_CNT'(1);
            if (byte_cnt_q == LAST_BYTE) begin
                tx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regbank_dump_controller.sv
// Debug-side sequencer that halts the pipeline, walks the register bank through
// the read-A port and streams every word LSB byte first to the UART transmitter.
// Ports:
//   clock_i, reset_i   clock and asynchronous active-low reset
//   dump_start_i       single-cycle dump request (ignored while busy)
//   abort_i            abandon a dump in progress
//   halt_o/halt_ack_i  pipeline freeze request / acknowledge
//   dbg_sel_o          read-A address taken from dbg_addr_o
//   dbg_addr_o         register index being read
//   rd_data_i          bank read-A data
//   tx_data_o/tx_valid_o/tx_ready_i  byte stream to the transmitter
//   busy_o             dump in progress
//   done_o             one-cycle pulse when a dump completes
module regbank_dump_controller
    import regbank_dump_controller_pkg::*;
#(
    parameter int unsigned NB_REG     = 5,
    parameter int unsigned NB_DATA    = 32,
    parameter int unsigned N_REGISTER = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   dump_start_i,
    input  logic                   abort_i,
    output logic                   halt_o,
    input  logic                   halt_ack_i,
    output logic                   dbg_sel_o,
    output logic [NB_REG-1:0]      dbg_addr_o,
    input  logic [NB_DATA-1:0]     rd_data_i,
    output logic [NB_DBG_BYTE-1:0] tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned N_BYTES = bytes_per_word(NB_DATA);
    localparam int unsigned NB_LAT  = cnt_width(RD_LATENCY);
    localparam logic [NB_LAT-1:0] LAT_LAST = NB_LAT'(RD_LATENCY - 1);
    localparam logic [NB_REG-1:0] IDX_LAST = NB_REG'(N_REGISTER - 1);

    state_e              state_q, state_d;
    logic [NB_REG-1:0]   idx_q, idx_d;
    logic [NB_LAT-1:0]   lat_q, lat_d;
    logic                halt_d, sel_d, busy_d, done_d;
    logic [NB_REG-1:0]   addr_d;
    logic                load_c, clear_c, last_byte_sent_c;

    // State, index, latency counter and registered outputs.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            lat_q      <= '0;
            halt_o     <= 1'b0;
            dbg_sel_o  <= 1'b0;
            dbg_addr_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            halt_o     <= halt_d;
            dbg_sel_o  <= sel_d;
            dbg_addr_o <= addr_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
        end
    end

    // Next state, and outputs decoded from the next state so they register in step.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        load_c  = 1'b0;
        clear_c = 1'b0;
        halt_d  = 1'b0;
        sel_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        addr_d  = '0;

        // Abort outranks everything, including a byte finishing this cycle.
        if ((state_q != ST_IDLE) && abort_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            lat_d   = '0;
            clear_c = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dump_start_i && !abort_i) begin
                        state_d = ST_HALT_REQ;
                        idx_d   = '0;
                    end
                end
                ST_HALT_REQ: begin
                    if (halt_ack_i) begin
                        state_d = ST_ADDR;
                        lat_d   = '0;
                    end
                end
                ST_ADDR: begin
                    if (lat_q == LAT_LAST) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        lat_d = lat_q + NB_LAT'(1);
                    end
                end
                ST_CAPTURE: begin
                    load_c  = 1'b1;
                    state_d = ST_SEND;
                end
                ST_SEND: begin
                    if (last_byte_sent_c) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + NB_REG'(1);
                            lat_d   = '0;
                            state_d = ST_ADDR;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        halt_d = (state_d != ST_IDLE);
        busy_d = (state_d != ST_IDLE);
        sel_d  = (state_d inside {ST_ADDR, ST_CAPTURE, ST_SEND, ST_DONE});
        done_d = (state_d == ST_DONE);
        addr_d = sel_d ? idx_d : '0;
    end

    word_byte_serializer #(
        .N_BYTES          (N_BYTES)
    ) u_serializer (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .clear            (clear_c),
        .load             (load_c),
        .word             (rd_data_i),
        .tx_ready_i       (tx_ready_i),
        .tx_data_o        (tx_data_o),
        .tx_valid_o       (tx_valid_o),
        .last_byte_sent_c (last_byte_sent_c)
    );

endmodule

// File: tb/tb_regbank_dump_controller.sv
// Self-checking bench: a behavioural register bank plus an expected byte queue
// built from the register contents; directed and randomized dumps.
module tb_regbank_dump_controller;

    localparam int unsigned NB_REG     = 5;
    localparam int unsigned NB_DATA    = 32;
    localparam int unsigned N_REGISTER = 32;
    localparam int unsigned RD_LATENCY = 1;
    localparam int unsigned BYTES      = NB_DATA / 8;

    logic               clock_i;
    logic               reset_i;
    logic               dump_start_i;
    logic               abort_i;
    logic               halt_o;
    logic               halt_ack_i;
    logic               dbg_sel_o;
    logic [NB_REG-1:0]  dbg_addr_o;
    logic [NB_DATA-1:0] rd_data_i;
    logic [7:0]         tx_data_o;
    logic               tx_valid_o;
    logic               tx_ready_i;
    logic               busy_o;
    logic               done_o;

    regbank_dump_controller #(
        .NB_REG       (NB_REG),
        .NB_DATA      (NB_DATA),
        .N_REGISTER   (N_REGISTER),
        .RD_LATENCY   (RD_LATENCY)
    ) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .dump_start_i (dump_start_i),
        .abort_i      (abort_i),
        .halt_o       (halt_o),
        .halt_ack_i   (halt_ack_i),
        .dbg_sel_o    (dbg_sel_o),
        .dbg_addr_o   (dbg_addr_o),
        .rd_data_i    (rd_data_i),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Register bank: synchronous read, garbage when the debug port is not selected.
    logic [NB_DATA-1:0] regs [N_REGISTER];
    always @(posedge clock_i) begin
        rd_data_i <= dbg_sel_o ? regs[dbg_addr_o] : 32'($urandom());
    end

    int         checks;
    int         failures;
    logic [7:0] exp_q [$];
    int         sent;
    int         done_seen;
    int         busy_cnt;
    int         hreq_cnt;
    int         sel_run;
    bit         first_seen;
    bit         prev_valid;
    logic [7:0] prev_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle observation of registered outputs at the falling edge.
    task automatic observe();
        if (prev_valid) begin
            chk("hold_valid", 64'(tx_valid_o), 64'(1));
            chk("hold_data", 64'(tx_data_o), 64'(prev_data));
        end
        if (dbg_sel_o) begin
            sel_run++;
            chk("sel_span_halt_busy", 64'({halt_o, busy_o}), 64'(2'b11));
        end
        if (tx_valid_o && !first_seen) begin
            first_seen = 1'b1;
            chk("first_byte_latency", 64'(sel_run), 64'(RD_LATENCY + 2));
        end
        if (done_o) done_seen++;
        if (busy_o) busy_cnt++;
        if (halt_o && !dbg_sel_o) hreq_cnt++;
    endtask

    // Once inputs for the coming edge are final: score a byte if it transfers.
    task automatic commit();
        bit taken;
        taken = tx_valid_o && tx_ready_i && !abort_i && reset_i;
        if (taken) begin
            if (exp_q.size() > 0) chk("byte", 64'(tx_data_o), 64'(exp_q.pop_front()));
            sent++;
        end
        prev_valid = tx_valid_o && !taken && !abort_i;
        prev_data  = tx_data_o;
    endtask

    // ready_mode: 0 held high, 1 toggling, 2 random.
    task automatic run_dump(input int ready_mode, input int ack_delay, input bit ack_jitter,
                            input int abort_at, input int restart_at, input int stop_at);
        int halt_seen;
        bit ack_given;
        bit abort_done;
        bit restarted;
        bit timed_out;
        exp_q.delete();
        for (int i = 0; i < int'(N_REGISTER); i++)
            for (int b = 0; b < int'(BYTES); b++)
                exp_q.push_back(8'(regs[i] >> (8 * b)));
        sent = 0; done_seen = 0; busy_cnt = 0; hreq_cnt = 0; sel_run = 0;
        first_seen = 1'b0; prev_valid = 1'b0;
        halt_seen = 0; ack_given = 1'b0; abort_done = 1'b0; restarted = 1'b0;
        timed_out = 1'b1;
        @(negedge clock_i);
        dump_start_i = 1'b1;
        halt_ack_i   = 1'b0;
        tx_ready_i   = (ready_mode == 1) ? 1'b0 : 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock_i);
            if (!ack_given) chk("halt_wait", 64'({halt_o, dbg_sel_o, tx_valid_o}), 64'(3'b100));
            observe();
            if (abort_done || done_seen > 0 || (stop_at >= 0 && sent == stop_at && tx_valid_o)) begin
                timed_out = 1'b0;
                break;
            end
            dump_start_i = 1'b0;
            abort_i      = 1'b0;
            case (ready_mode)
                0:       tx_ready_i = 1'b1;
                1:       tx_ready_i = ~tx_ready_i;
                default: tx_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (halt_o) halt_seen++;
            if (ack_given) begin
                halt_ack_i = ack_jitter ? 1'($urandom_range(0, 1)) : 1'b1;
            end else if (halt_seen >= ack_delay) begin
                halt_ack_i = 1'b1;
                ack_given  = 1'b1;
            end
            if (abort_at >= 0 && sent == abort_at && tx_valid_o) begin
                abort_i    = 1'b1;
                tx_ready_i = 1'b1;
                abort_done = 1'b1;
            end
            if (restart_at >= 0 && sent == restart_at && tx_valid_o && !restarted) begin
                dump_start_i = 1'b1;
                restarted    = 1'b1;
            end
            commit();
        end
        dump_start_i = 1'b0;
        chk("timeout", 64'(timed_out), 64'(0));
    endtask

    task automatic finish_checks(input bit min_time);
        halt_ack_i = 1'b0;
        tx_ready_i = 1'b0;
        abort_i    = 1'b0;
        @(negedge clock_i);
        chk("after_done", 64'({halt_o, dbg_sel_o, busy_o, done_o, tx_valid_o}), 64'(0));
        repeat (3) begin
            @(negedge clock_i);
            if (done_o) done_seen++;
        end
        chk("done_once", 64'(done_seen), 64'(1));
        chk("byte_count", 64'(sent), 64'(N_REGISTER * BYTES));
        if (min_time)
            chk("dump_time", 64'(busy_cnt), 64'(hreq_cnt + N_REGISTER * (RD_LATENCY + 1 + BYTES) + 1));
    endtask

    task automatic ramp_regs();
        for (int i = 0; i < int'(N_REGISTER); i++) regs[i] = 32'h1000_0000 + 32'(i);
    endtask

    task automatic random_regs();
        for (int i = 0; i < int'(N_REGISTER); i++) regs[i] = 32'($urandom());
    endtask

    initial begin
        checks = 0; failures = 0;
        reset_i = 1'b0; dump_start_i = 1'b0; abort_i = 1'b0;
        halt_ack_i = 1'b0; tx_ready_i = 1'b0;
        ramp_regs();
        repeat (3) @(negedge clock_i);
        chk("reset_state", 64'({halt_o, dbg_sel_o, dbg_addr_o, tx_data_o, tx_valid_o, busy_o, done_o}), 64'(0));
        reset_i = 1'b1;

        // Ramp pattern, halt ack three cycles after halt, ready held high.
        run_dump(0, 3, 1'b0, -1, -1, -1);
        finish_checks(1'b1);

        // Random contents, ready toggling every cycle.
        random_regs();
        run_dump(1, 3, 1'b0, -1, -1, -1);
        finish_checks(1'b0);

        // Long halt handshake.
        ramp_regs();
        run_dump(0, 50, 1'b0, -1, -1, -1);
        finish_checks(1'b1);

        // Random contents, random ready, random ack delay, ack dropping after the handshake.
        random_regs();
        run_dump(2, int'($urandom_range(1, 8)), 1'b1, -1, -1, -1);
        finish_checks(1'b0);

        // Abort while byte 2 of r5 is presented, then a fresh dump from r0.
        ramp_regs();
        run_dump(0, 3, 1'b0, 5 * BYTES + 2, -1, -1);
        chk("abort_outputs", 64'({halt_o, dbg_sel_o, tx_valid_o, busy_o, done_o}), 64'(0));
        chk("abort_sent", 64'(sent), 64'(5 * BYTES + 2));
        abort_i = 1'b0; halt_ack_i = 1'b0;
        repeat (4) begin
            @(negedge clock_i);
            if (done_o) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'(0));
        run_dump(0, 3, 1'b0, -1, -1, -1);
        finish_checks(1'b1);

        // Start re-pulsed during SEND of r10.
        random_regs();
        run_dump(0, 3, 1'b0, -1, 10 * BYTES, -1);
        finish_checks(1'b1);

        // Start and abort together in IDLE.
        @(negedge clock_i);
        dump_start_i = 1'b1; abort_i = 1'b1;
        @(negedge clock_i);
        chk("start_abort_idle", 64'({busy_o, halt_o}), 64'(0));
        dump_start_i = 1'b0; abort_i = 1'b0;

        // Asynchronous reset mid-SEND, off the clock edges.
        run_dump(0, 3, 1'b0, -1, -1, 12 * BYTES + 2);
        #2 reset_i = 1'b0;
        #1 chk("reset_async", 64'({halt_o, dbg_sel_o, dbg_addr_o, tx_data_o, tx_valid_o, busy_o, done_o}), 64'(0));
        halt_ack_i = 1'b0; tx_ready_i = 1'b0;
        #13 reset_i = 1'b1;
        @(negedge clock_i);
        chk("post_reset_idle", 64'({halt_o, dbg_sel_o, tx_valid_o, busy_o, done_o}), 64'(0));
        random_regs();
        run_dump(2, 2, 1'b0, -1, -1, -1);
        finish_checks(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
